// File: rtl/rx_instr.sv
// UART 8N1 receiver that packs four little-endian bytes into one 32-bit instruction word.
// The word is valid on the edge after the 4th stop-bit sample; a byte arriving while a word is held (not accepted) is dropped with an overrun pulse.
module rx_instr #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 12000
) (
    input  logic        clk12,
    input  logic        rst,
    input  logic        rx,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        rx_busy,
    output logic        frame_err,
    output logic        overrun,
    output logic        led
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          byte_done, byte_done_nxt;
    logic          frame_err_nxt;

    logic          rx_meta, rs;
    logic [1:0]    warm;
    logic          armed;

    logic [1:0]    byte_idx;
    logic [23:0]   word;
    logic [TW-1:0] to_cnt;
    logic          accept;

    // warm delays arming until rs carries a real sample of rx, not the reset value
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
            warm    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
            warm    <= {warm[0], 1'b1};
            if (warm[1] && rs)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            byte_done <= byte_done_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clk_cnt_nxt   = clk_cnt;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        byte_done_nxt = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rs) begin
                    state_nxt   = START;
                    clk_cnt_nxt = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = rs ? IDLE : DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rs, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = STOP;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt   = '0;
                    state_nxt     = IDLE;
                    byte_done_nxt = rs;
                    frame_err_nxt = !rs;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);
    assign accept  = instr_valid && instr_ready;

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            overrun     <= 1'b0;
            led         <= 1'b0;
            byte_idx    <= '0;
            word        <= '0;
            to_cnt      <= '0;
        end else begin
            overrun <= 1'b0;
            if (accept)
                instr_valid <= 1'b0;
            if (byte_done) begin
                if (instr_valid && !accept) begin
                    overrun <= 1'b1;
                end else if (byte_idx == 2'd3) begin
                    instr       <= {shift, word};
                    instr_valid <= 1'b1;
                    byte_idx    <= '0;
                    led         <= ~led;
                end else begin
                    word[8*byte_idx +: 8] <= shift;
                    byte_idx              <= byte_idx + 1'b1;
                end
            end
            // inter-byte timeout only runs while a partial word is pending
            if (byte_done || byte_idx == 2'd0) begin
                to_cnt <= '0;
            end else if (state == IDLE) begin
                if (to_cnt == TO_LAST) begin
                    to_cnt   <= '0;
                    byte_idx <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
            if (frame_err)
                byte_idx <= '0;
        end
    end

endmodule

// File: tb/tb_rx_instr.sv
// Bench for rx_instr: serial stimulus with an expected-word queue checked on every accepted word.
module tb_rx_instr;

    localparam int CPB = 104;
    localparam int TO  = 12000;

    logic        clk12 = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;
    logic        led;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    int          vld_cycles = 0;
    logic        led_exp = 1'b0;
    logic [31:0] prev_instr = '0;
    logic        hold = 1'b0;
    logic [31:0] exp_w;

    rx_instr #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk12(clk12), .rst(rst), .rx(rx),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rx_busy(rx_busy), .frame_err(frame_err), .overrun(overrun), .led(led)
    );

    always #5 clk12 = ~clk12;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk12);
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rx = b;
        cyc(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(b[i], CPB);
        if (stop_ok) begin
            send_bit(1'b1, CPB);
        end else begin
            send_bit(1'b0, CPB * 3 / 4);
            send_bit(1'b1, CPB + CPB / 4);
        end
        send_bit(1'b1, 8);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(5);
        n_checks += 6;
        if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h, required 0", instr); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", rx_busy); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        if (led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b, required 0", led); end
        rst = 1'b0;
        led_exp = 1'b0;
        cyc(20);
    endtask

    task automatic test_basic;
        int v0, f0, o0;
        v0 = vld_cycles; f0 = fe_cnt; o0 = ov_cnt;
        instr_ready = 1'b1;
        exp_q.push_back(32'h10000513); led_exp = ~led_exp;
        send_word(32'h10000513);
        cyc(20);
        n_checks += 5;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_pending: got %0d words outstanding, required 0", exp_q.size()); end
        if (vld_cycles - v0 != 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d cycles, required 1", vld_cycles - v0); end
        if (led !== led_exp) begin n_fail++; $display("FAIL basic_led: got %b, required %b", led, led_exp); end
        if (fe_cnt != f0) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses, required 0", fe_cnt - f0); end
        if (ov_cnt != o0) begin n_fail++; $display("FAIL basic_overrun: got %0d pulses, required 0", ov_cnt - o0); end
    endtask

    task automatic test_overrun;
        int o0;
        o0 = ov_cnt;
        instr_ready = 1'b0;
        send_word(32'h10000513); led_exp = ~led_exp;
        cyc(10);
        n_checks += 2;
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_held_valid: got %b, required 1", instr_valid); end
        if (instr !== 32'h10000513) begin n_fail++; $display("FAIL ovr_held_instr: got %h, required 10000513", instr); end
        send_byte(8'hAA, 1'b1);
        cyc(10);
        n_checks += 3;
        if (ov_cnt - o0 != 1) begin n_fail++; $display("FAIL ovr_pulse: got %0d pulses, required 1", ov_cnt - o0); end
        if (instr !== 32'h10000513) begin n_fail++; $display("FAIL ovr_instr_kept: got %h, required 10000513", instr); end
        if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_kept: got %b, required 1", instr_valid); end
        exp_q.push_back(32'h10000513);
        instr_ready = 1'b1;
        cyc(3);
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovr_accept: got %0d words outstanding, required 0", exp_q.size()); end
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid_clear: got %b, required 0", instr_valid); end
        exp_q.push_back(32'h04030201); led_exp = ~led_exp;
        send_word(32'h04030201);
        cyc(20);
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovr_next_word: got %0d words outstanding, required 0", exp_q.size()); end
        if (led !== led_exp) begin n_fail++; $display("FAIL ovr_led: got %b, required %b", led, led_exp); end
    endtask

    task automatic test_timeout;
        exp_q.push_back(32'h66554433); led_exp = ~led_exp;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        cyc(TO + 200);
        send_word(32'h66554433);
        cyc(20);
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL timeout_word: got %0d words outstanding, required 0", exp_q.size()); end
        if (led !== led_exp) begin n_fail++; $display("FAIL timeout_led: got %b, required %b", led, led_exp); end
    endtask

    task automatic test_frame_err;
        int f0, o0;
        f0 = fe_cnt; o0 = ov_cnt;
        send_byte(8'h7F, 1'b0);
        cyc(CPB);
        exp_q.push_back(32'h04030201); led_exp = ~led_exp;
        send_word(32'h04030201);
        cyc(20);
        n_checks += 3;
        if (fe_cnt - f0 != 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d pulses, required 1", fe_cnt - f0); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ferr_word: got %0d words outstanding, required 0", exp_q.size()); end
        if (ov_cnt != o0) begin n_fail++; $display("FAIL ferr_overrun: got %0d pulses, required 0", ov_cnt - o0); end
    endtask

    task automatic test_glitch;
        int f0, o0, v0;
        f0 = fe_cnt; o0 = ov_cnt; v0 = vld_cycles;
        rx = 1'b0;
        cyc(10);
        n_checks++;
        if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start_seen: got %b, required 1", rx_busy); end
        cyc(10);
        rx = 1'b1;
        cyc(60);
        n_checks += 4;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_drop: got %b, required 0", rx_busy); end
        if (fe_cnt != f0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d pulses, required 0", fe_cnt - f0); end
        if (ov_cnt != o0) begin n_fail++; $display("FAIL glitch_overrun: got %0d pulses, required 0", ov_cnt - o0); end
        if (vld_cycles != v0) begin n_fail++; $display("FAIL glitch_word: got %0d valid cycles, required 0", vld_cycles - v0); end
        exp_q.push_back(32'hCAFEF00D); led_exp = ~led_exp;
        send_word(32'hCAFEF00D);
        cyc(20);
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL glitch_align: got %0d words outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midframe;
        int f0;
        instr_ready = 1'b1;
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);
        send_bit(1'b0, CPB / 2);
        rst = 1'b1;
        cyc(3);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_in_reset: got %b, required 0", rx_busy); end
        rst = 1'b0;
        led_exp = 1'b0;
        f0 = fe_cnt;
        cyc(250);
        n_checks++;
        if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_low_line: got busy %b, required 0", rx_busy); end
        cyc(250);
        rx = 1'b1;
        cyc(200);
        exp_q.push_back(32'hEFBEADDE); led_exp = ~led_exp;
        send_word(32'hEFBEADDE);
        cyc(20);
        n_checks += 3;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midrst_word: got %0d words outstanding, required 0", exp_q.size()); end
        if (led !== 1'b1) begin n_fail++; $display("FAIL midrst_led: got %b, required 1", led); end
        if (fe_cnt != f0) begin n_fail++; $display("FAIL midrst_frame_err: got %0d pulses, required 0", fe_cnt - f0); end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk12);
                if (rst) begin
                    hold = 1'b0;
                end else begin
                    if (hold) begin
                        n_checks++;
                        if (instr !== prev_instr) begin
                            n_fail++;
                            $display("FAIL instr_stable: got %h, required %h", instr, prev_instr);
                        end
                    end
                    if (instr_valid && instr_ready) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL word_unexpected: got %h, required no word", instr);
                        end else begin
                            exp_w = exp_q.pop_front();
                            if (instr !== exp_w) begin
                                n_fail++;
                                $display("FAIL word_value: got %h, required %h", instr, exp_w);
                            end
                        end
                    end
                    fe_cnt     += int'(frame_err);
                    ov_cnt     += int'(overrun);
                    vld_cycles += int'(instr_valid);
                    hold       = instr_valid && !instr_ready;
                    prev_instr = instr;
                end
            end
        join_none

        test_reset();
        test_basic();
        test_overrun();
        test_timeout();
        test_frame_err();
        test_glitch();
        test_reset_midframe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_instr.md
Name: rx_instr

Overview:
- UART receive stage: deserialises bytes on `rx`, assembles each group of 4 bytes into one 32-bit instruction word, and presents it to the core with a valid/ready handshake.
- Sits directly upstream of the core; the core's register file is later returned by the TX register-file dumper.
- Byte order is little-endian (first byte = bits [7:0]), matching the LSB-first byte order of the register-file dump.
- Self-contained: contains its own oversampling bit receiver, inter-byte timeout and overrun detection.

Parameters:
CLKS_PER_BIT, 104, clk12 cycles per UART bit (12 MHz / 115200, integer-truncated); must be >= 4
TIMEOUT_CLKS, 12000, idle clk12 cycles after which a partially assembled word is discarded (1 ms at 12 MHz)

Ports:
clk12  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
rx  input  1  UART serial input, idle high, 8N1, asynchronous to clk12
instr  output  32  assembled instruction; stable while instr_valid=1
instr_valid  output  1  instr holds a complete word
instr_ready  input  1  consumer accepts instr when instr_valid&&instr_ready at a clock edge
rx_busy  output  1  bit receiver is inside a frame (start..stop)
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while instr_valid=1 and not being accepted; byte dropped
led  output  1  toggles on each word completion

Behaviour:
- Reset values: instr=0, instr_valid=0, rx_busy=0, frame_err=0, overrun=0, led=0, byte_index=0, bit FSM=IDLE, 2-flop rx synchroniser=1, armed=0.
- Synchroniser: rx passes through 2 flops; all decisions use the synchronised value rs. Latency is 2 cycles, which is ignored for bit timing.
- Arming: after reset the receiver sets armed=1 only once rs has been 1 for one cycle. A line held low through reset release is never taken as a start bit.

Bit FSM (bit counter 0..7, clock counter 0..CLKS_PER_BIT-1):
- IDLE: if armed and rs==0, go to START with the clock counter cleared; rx_busy=1 from that edge.
- START: wait CLKS_PER_BIT/2 cycles. If rs==0, go to DATA with the clock counter cleared. If rs==1 (glitch), go to IDLE with no pulse.
- DATA: every CLKS_PER_BIT cycles sample rs into the shift register, LSB first. After the 8th sample, go to STOP.
- STOP: after CLKS_PER_BIT cycles sample rs.
  - rs==1: the byte is good; raise the internal byte_done strobe for 1 cycle.
  - rs==0: pulse frame_err, set byte_index to 0, drop the byte.
  - In both cases go to IDLE in the same edge and drop rx_busy. A new start bit may be detected on the next cycle.

Assembler, on byte_done:
- Drop case: if instr_valid==1 and not (instr_valid&&instr_ready) this cycle, pulse overrun and drop the byte; byte_index is unchanged.
- Otherwise write the byte to word[8*byte_index +: 8].
- If byte_index==3: copy the full word to instr (including this byte), set instr_valid=1, set byte_index=0, toggle led. instr_valid rises on the edge after the stop-bit sample edge.
- Else: increment byte_index.

Handshake:
- instr_valid clears on the edge where instr_valid&&instr_ready.
- instr is never modified while instr_valid=1.
- Accept and word completion in the same cycle: the accept wins; the new word loads and instr_valid stays 1 with no bubble and no overrun.

Timeout:
- Timeout counter clears on every byte_done and whenever byte_index==0.
- Otherwise it counts while the bit FSM is IDLE. On reaching TIMEOUT_CLKS: byte_index=0, partial word discarded, no pulse.

Reset mid-frame: all state returns to reset values immediately. The remainder of the frame is ignored via the arming rule.

Simultaneous frame_err and timeout expiry: both set byte_index=0; there is no conflict.

Test Plan:
- Send bytes 0x13,0x05,0x00,0x10 at 104 clk/bit with instr_ready=1 -> one-cycle instr_valid with instr=0x10000513, led 0->1, no frame_err/overrun.
- Send the same word with instr_ready=0, then 1 extra byte 0xAA -> instr_valid held with instr=0x10000513, overrun pulses once, byte_index remains 0. Raise ready, then send 0x01,0x02,0x03,0x04 -> instr=0x04030201.
- Send 0x11,0x22, idle 12000 cycles, send 0x33,0x44,0x55,0x66 -> single word instr=0x66554433; 0x11/0x22 discarded.
- Byte 0x7F with stop bit forced low, then 4 good bytes 0x01..0x04 -> frame_err pulses once; instr=0x04030201.
- 20-cycle low glitch on idle rx -> no rx_busy after the START check, no byte, no pulses.
- Assert rst during the 2nd data bit of byte 1 with rx held low for 500 cycles after release, then send 0xDE,0xAD,0xBE,0xEF -> no spurious byte; instr=0xEFBEADDE, led=1.
